// File: rtl/rram_pkg.sv
// rtl/rram_pkg.sv - shared constants, accumulator FSM state type and saturating shift-add
package rram_pkg;
  localparam int NUM_ADC       = 32;
  localparam int ADC_WIDTH     = 4;
  localparam int DATAOUT_WIDTH = 64;
  // Headroom for any accumulator up to 31 bits after the shift plus sign.
  localparam int SUM_WIDTH     = 34;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} acc_state_e;

  function automatic logic signed [SUM_WIDTH-1:0] sat_add(
    input logic signed [SUM_WIDTH-1:0] acc,
    input logic signed [SUM_WIDTH-1:0] term,
    input int unsigned                 width,
    input logic                        is_signed
  );
    logic signed [SUM_WIDTH-1:0] one, sum, hi, lo, res;
    one = SUM_WIDTH'(1);
    sum = (acc <<< 1) + term;
    if (is_signed) begin
      hi = (one <<< (width - 1)) - one;
      lo = ~hi;
    end else begin
      hi = (one <<< width) - one;
      lo = '0;
    end
    if (sum > hi) begin
      res = hi;
    end else if (sum < lo) begin
      res = lo;
    end else begin
      res = sum;
    end
    return res;
  endfunction
endpackage

// File: rtl/rram_mvm_accumulator_if.sv
// rtl/rram_mvm_accumulator_if.sv - ADC bit-plane input stream and packed readout stream
interface rram_mvm_accumulator_if;
  import rram_pkg::*;

  logic                              adc_valid_i;
  logic                              adc_last_i;
  logic                              adc_ready_o;
  logic [NUM_ADC-1:0][ADC_WIDTH-1:0] ADCOUT;
  logic [DATAOUT_WIDTH-1:0]          DATAOUT;
  logic                              valid_o;
  logic                              ready_i;
  logic                              busy_o;
  logic                              overflow_o;

  modport master (
    output adc_valid_i, adc_last_i, ADCOUT, ready_i,
    input  adc_ready_o, DATAOUT, valid_o, busy_o, overflow_o
  );

  modport slave (
    input  adc_valid_i, adc_last_i, ADCOUT, ready_i,
    output adc_ready_o, DATAOUT, valid_o, busy_o, overflow_o
  );
endinterface

// File: rtl/rram_acc_lane.sv
// rtl/rram_acc_lane.sv - one column's shift-add-saturate accumulator with per-frame clear
module rram_acc_lane
  import rram_pkg::*;
#(
  parameter int ACC_WIDTH  = 16,
  parameter bit SIGNED_ACC = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 load_i,
  input  logic                 first_i,
  input  logic [ADC_WIDTH-1:0] code_i,
  output logic [ACC_WIDTH-1:0] acc_o,
  output logic                 sat_o
);
  logic [ACC_WIDTH-1:0]        acc_q;
  logic [ACC_WIDTH-1:0]        acc_d;
  logic signed [SUM_WIDTH-1:0] base;
  logic signed [SUM_WIDTH-1:0] term;
  logic signed [SUM_WIDTH-1:0] sum;
  logic signed [SUM_WIDTH-1:0] clamped;

  // The first plane starts from zero; in signed mode it is the negative-weight MSB plane.
  always_comb begin
    base = '0;
    if (!first_i) begin
      if (SIGNED_ACC) begin
        base = SUM_WIDTH'(signed'(acc_q));
      end else begin
        base = SUM_WIDTH'(acc_q);
      end
    end
    term = SUM_WIDTH'(code_i);
    if (SIGNED_ACC && first_i) begin
      term = -term;
    end
    sum     = (base <<< 1) + term;
    clamped = sat_add(base, term, ACC_WIDTH, SIGNED_ACC);
    sat_o   = (clamped != sum);
    acc_d   = ACC_WIDTH'(clamped);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      acc_q <= '0;
    end else if (load_i) begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/rram_mvm_accumulator.sv
// rtl/rram_mvm_accumulator.sv - bit-serial MVM shift-add accumulator with packed word drain
// Optional RRAM_ACC_SIGNED_EN: two's-complement planes, signed saturating accumulators.
module rram_mvm_accumulator
  import rram_pkg::*;
#(
  parameter int ACC_WIDTH = 16,
  parameter int IN_BITS   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  rram_mvm_accumulator_if.slave bus
);
  localparam int LANES_PER_WORD = DATAOUT_WIDTH / ACC_WIDTH;
  localparam int NUM_WORDS      = NUM_ADC / LANES_PER_WORD;
  localparam int WIDX_W         = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int CNT_W          = $clog2(IN_BITS + 1);
`ifdef RRAM_ACC_SIGNED_EN
  localparam bit SIGNED_ACC = 1'b1;
`else
  localparam bit SIGNED_ACC = 1'b0;
`endif

  acc_state_e                               state_q;
  logic [CNT_W-1:0]                         cnt_q;
  logic [WIDX_W-1:0]                        widx_q;
  logic                                     valid_q;
  logic                                     overflow_q;
  logic                                     accept;
  logic                                     last_beat;
  logic                                     drain_done;
  logic                                     any_sat;
  logic [NUM_ADC-1:0]                       sat_vec;
  logic [NUM_ADC-1:0][ACC_WIDTH-1:0]        acc_all;
  logic [NUM_WORDS-1:0][DATAOUT_WIDTH-1:0]  words;

  assign accept     = bus.adc_valid_i && (state_q != DRAIN);
  // cnt_q is zero in IDLE, so the same compare forces DRAIN on the IN_BITS-th beat from either state.
  assign last_beat  = bus.adc_last_i || (cnt_q == CNT_W'(IN_BITS - 1));
  assign drain_done = (state_q == DRAIN) && valid_q && bus.ready_i
                      && (widx_q == WIDX_W'(NUM_WORDS - 1));
  assign any_sat    = |sat_vec;

  for (genvar g = 0; g < NUM_ADC; g++) begin : g_lane
    rram_acc_lane #(
      .ACC_WIDTH  (ACC_WIDTH),
      .SIGNED_ACC (SIGNED_ACC)
    ) u_lane (
      .clk_i   (CLK),
      .rst_i   (RST),
      .clear_i (drain_done),
      .load_i  (accept),
      .first_i (state_q == IDLE),
      .code_i  (bus.ADCOUT[g]),
      .acc_o   (acc_all[g]),
      .sat_o   (sat_vec[g])
    );
  end

  assign words = acc_all;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      widx_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            cnt_q      <= cnt_q + 1'b1;
            overflow_q <= ((state_q == ACCUM) && overflow_q) || any_sat;
            if (last_beat) begin
              state_q <= DRAIN;
              valid_q <= 1'b1;
              widx_q  <= '0;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        DRAIN: begin
          if (valid_q && bus.ready_i) begin
            if (drain_done) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              cnt_q   <= '0;
              widx_q  <= '0;
            end else begin
              widx_q <= widx_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.adc_ready_o = (state_q != DRAIN);
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.valid_o     = valid_q;
  assign bus.overflow_o  = overflow_q;
  assign bus.DATAOUT     = valid_q ? words[widx_q] : '0;
endmodule

// File: tb/tb_rram_mvm_accumulator.sv
// tb/tb_rram_mvm_accumulator.sv - directed self-checking bench for rram_mvm_accumulator
module tb_rram_mvm_accumulator;
  import rram_pkg::*;

`ifdef RRAM_ACC_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   failures = 0;
  logic [DATAOUT_WIDTH-1:0] got [8];
  int   got_n;

  always #5 CLK = ~CLK;

  rram_mvm_accumulator_if bus ();
  rram_mvm_accumulator_if bus8 ();

  rram_mvm_accumulator #(.ACC_WIDTH(16), .IN_BITS(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  rram_mvm_accumulator #(.ACC_WIDTH(8), .IN_BITS(8)) dut8 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus8)
  );

  task automatic beat(input logic [NUM_ADC-1:0][ADC_WIDTH-1:0] codes, input logic last);
    @(negedge CLK);
    bus.adc_valid_i = 1'b1;
    bus.adc_last_i  = last;
    bus.ADCOUT      = codes;
  endtask

  task automatic idle_in();
    @(negedge CLK);
    bus.adc_valid_i = 1'b0;
    bus.adc_last_i  = 1'b0;
    bus.ADCOUT      = '0;
  endtask

  task automatic collect8();
    got_n = 0;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 8; i++) got[i] = '0;
    for (int cyc = 0; cyc < 40 && got_n < 8; cyc++) begin
      if (bus.valid_o) begin
        got[got_n] = bus.DATAOUT;
        got_n++;
      end
      @(negedge CLK);
    end
  endtask

  task automatic full_scale_frame();
    for (int i = 0; i < 8; i++) beat({NUM_ADC{4'hF}}, i == 7);
    idle_in();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checks += 7;
    if (bus.DATAOUT !== 64'h0) begin failures++; $display("FAIL reset_dataout got=%h exp=0", bus.DATAOUT); end
    if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.valid_o); end
    if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    if (bus.overflow_o !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow_o); end
    if (bus.adc_ready_o !== 1'b1) begin failures++; $display("FAIL reset_adc_ready got=%b exp=1", bus.adc_ready_o); end
    if (bus8.adc_ready_o !== 1'b1) begin failures++; $display("FAIL reset8_adc_ready got=%b exp=1", bus8.adc_ready_o); end
    if (bus8.valid_o !== 1'b0) begin failures++; $display("FAIL reset8_valid got=%b exp=0", bus8.valid_o); end
    RST = 1'b0;
  endtask

  task automatic test_full_scale();
    logic [63:0] exp_w;
    exp_w = SGN ? {4{16'hFFF1}} : {4{16'h0EF1}};
    full_scale_frame();
    checks += 3;
    if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL fs_first_valid got=%b exp=1", bus.valid_o); end
    if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL fs_busy got=%b exp=1", bus.busy_o); end
    if (bus.adc_ready_o !== 1'b0) begin failures++; $display("FAIL fs_adc_ready got=%b exp=0", bus.adc_ready_o); end
    collect8();
    checks++;
    if (got_n !== 8) begin failures++; $display("FAIL fs_count got=%0d exp=8", got_n); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (got[k] !== exp_w) begin failures++; $display("FAIL fs_word%0d got=%h exp=%h", k, got[k], exp_w); end
    end
    checks += 3;
    if (bus.overflow_o !== 1'b0) begin failures++; $display("FAIL fs_overflow got=%b exp=0", bus.overflow_o); end
    if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL fs_end_valid got=%b exp=0", bus.valid_o); end
    if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL fs_end_busy got=%b exp=0", bus.busy_o); end
  endtask

  task automatic test_single_beat();
    logic [NUM_ADC-1:0][ADC_WIDTH-1:0] codes;
    logic [63:0] exp_w;
    logic [15:0] v;
    for (int i = 0; i < NUM_ADC; i++) codes[i] = 4'(i % 16);
    beat(codes, 1'b1);
    idle_in();
    collect8();
    checks++;
    if (got_n !== 8) begin failures++; $display("FAIL sb_count got=%0d exp=8", got_n); end
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) begin
        v = 16'((4 * k + j) % 16);
        exp_w[j*16 +: 16] = SGN ? (16'd0 - v) : v;
      end
      checks++;
      if (got[k] !== exp_w) begin failures++; $display("FAIL sb_word%0d got=%h exp=%h", k, got[k], exp_w); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_w;
    int n;
    bit stalled;
    exp_w = SGN ? {4{16'hFFF1}} : {4{16'h0EF1}};
    full_scale_frame();
    bus.ready_i = 1'b1;
    n = 0;
    stalled = 1'b0;
    for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
      checks++;
      if (bus.adc_ready_o !== 1'b0) begin failures++; $display("FAIL bp_adc_ready got=%b exp=0", bus.adc_ready_o); end
      if (n == 2 && !stalled) begin
        stalled = 1'b1;
        bus.ready_i = 1'b0;
        bus.adc_valid_i = 1'b1;
        bus.ADCOUT = {NUM_ADC{4'h7}};
        for (int s = 0; s < 5; s++) begin
          @(negedge CLK);
          checks++;
          if (bus.valid_o !== 1'b1 || bus.DATAOUT !== exp_w) begin
            failures++;
            $display("FAIL bp_hold got_valid=%b got_data=%h exp=%h", bus.valid_o, bus.DATAOUT, exp_w);
          end
        end
        bus.ready_i = 1'b1;
        bus.adc_valid_i = 1'b0;
        bus.ADCOUT = '0;
      end
      if (bus.valid_o && bus.ready_i) begin
        checks++;
        if (bus.DATAOUT !== exp_w) begin failures++; $display("FAIL bp_word%0d got=%h exp=%h", n, bus.DATAOUT, exp_w); end
        n++;
      end
      @(negedge CLK);
    end
    checks += 3;
    if (n !== 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", n); end
    if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL bp_extra_valid got=%b exp=0", bus.valid_o); end
    if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL bp_end_busy got=%b exp=0", bus.busy_o); end
  endtask

  task automatic test_force_drain();
    logic [63:0] exp_w;
    exp_w = SGN ? {4{16'hFFFF}} : {4{16'h00FF}};
    for (int i = 0; i < 8; i++) begin
      beat({NUM_ADC{4'h1}}, 1'b0);
      if (i == 3) begin
        idle_in();
        repeat (2) @(negedge CLK);
        checks += 3;
        if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL fd_gap_busy got=%b exp=1", bus.busy_o); end
        if (bus.adc_ready_o !== 1'b1) begin failures++; $display("FAIL fd_gap_ready got=%b exp=1", bus.adc_ready_o); end
        if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL fd_gap_valid got=%b exp=0", bus.valid_o); end
      end
    end
    idle_in();
    checks++;
    if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL fd_forced_valid got=%b exp=1", bus.valid_o); end
    collect8();
    checks++;
    if (got_n !== 8) begin failures++; $display("FAIL fd_count got=%0d exp=8", got_n); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (got[k] !== exp_w) begin failures++; $display("FAIL fd_word%0d got=%h exp=%h", k, got[k], exp_w); end
    end
  endtask

  task automatic test_saturation();
    logic [63:0] exp_w;
    int n;
    exp_w = SGN ? {8{8'h7F}} : {8{8'hFF}};
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      bus8.adc_valid_i = 1'b1;
      bus8.adc_last_i  = (i == 7);
      bus8.ADCOUT      = (i == 0 && SGN) ? {NUM_ADC{4'h0}} : {NUM_ADC{4'hF}};
    end
    @(negedge CLK);
    bus8.adc_valid_i = 1'b0;
    bus8.adc_last_i  = 1'b0;
    bus8.ready_i     = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      if (bus8.valid_o) begin
        checks += 2;
        if (bus8.DATAOUT !== exp_w) begin failures++; $display("FAIL sat_word%0d got=%h exp=%h", n, bus8.DATAOUT, exp_w); end
        if (bus8.overflow_o !== 1'b1) begin failures++; $display("FAIL sat_overflow got=%b exp=1", bus8.overflow_o); end
        n++;
      end
      @(negedge CLK);
    end
    checks += 2;
    if (n !== 4) begin failures++; $display("FAIL sat_count got=%0d exp=4", n); end
    if (bus8.overflow_o !== 1'b1) begin failures++; $display("FAIL sat_sticky got=%b exp=1", bus8.overflow_o); end
    bus8.adc_valid_i = 1'b1;
    bus8.ADCOUT      = {NUM_ADC{4'h1}};
    @(negedge CLK);
    bus8.adc_last_i  = 1'b1;
    bus8.ADCOUT      = '0;
    checks += 2;
    if (bus8.overflow_o !== 1'b0) begin failures++; $display("FAIL sat_clear got=%b exp=0", bus8.overflow_o); end
    if (bus8.busy_o !== 1'b1) begin failures++; $display("FAIL sat_next_busy got=%b exp=1", bus8.busy_o); end
    @(negedge CLK);
    bus8.adc_valid_i = 1'b0;
    bus8.adc_last_i  = 1'b0;
    checks++;
    if (bus8.DATAOUT !== (SGN ? {8{8'hFE}} : {8{8'h02}})) begin
      failures++;
      $display("FAIL sat_next_word0 got=%h exp=%h", bus8.DATAOUT, SGN ? {8{8'hFE}} : {8{8'h02}});
    end
    for (int cyc = 0; cyc < 20 && bus8.valid_o; cyc++) @(negedge CLK);
  endtask

  task automatic test_reset_mid_drain();
    logic [63:0] exp_w;
    int n;
    exp_w = SGN ? {4{16'hFFFF}} : 64'h0001000100010001;
    full_scale_frame();
    bus.ready_i = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      if (bus.valid_o) n++;
      @(negedge CLK);
    end
    RST = 1'b1;
    @(negedge CLK);
    checks += 5;
    if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.valid_o); end
    if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy_o); end
    if (bus.adc_ready_o !== 1'b1) begin failures++; $display("FAIL rst_adc_ready got=%b exp=1", bus.adc_ready_o); end
    if (bus.DATAOUT !== 64'h0) begin failures++; $display("FAIL rst_dataout got=%h exp=0", bus.DATAOUT); end
    if (n !== 4) begin failures++; $display("FAIL rst_pre_count got=%0d exp=4", n); end
    RST = 1'b0;
    beat({NUM_ADC{4'h1}}, 1'b1);
    idle_in();
    collect8();
    checks++;
    if (got_n !== 8) begin failures++; $display("FAIL rst_count got=%0d exp=8", got_n); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (got[k] !== exp_w) begin failures++; $display("FAIL rst_word%0d got=%h exp=%h", k, got[k], exp_w); end
    end
  endtask

  task automatic test_signed();
    logic [63:0] exp_w;
    exp_w = SGN ? {4{16'hFF80}} : {4{16'h0080}};
    for (int i = 0; i < 8; i++) beat((i == 0) ? {NUM_ADC{4'h1}} : {NUM_ADC{4'h0}}, i == 7);
    idle_in();
    collect8();
    checks += 2;
    if (got_n !== 8) begin failures++; $display("FAIL sg_count got=%0d exp=8", got_n); end
    if (bus.overflow_o !== 1'b0) begin failures++; $display("FAIL sg_overflow got=%b exp=0", bus.overflow_o); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (got[k] !== exp_w) begin failures++; $display("FAIL sg_word%0d got=%h exp=%h", k, got[k], exp_w); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    bus.adc_valid_i  = 1'b0;
    bus.adc_last_i   = 1'b0;
    bus.ADCOUT       = '0;
    bus.ready_i      = 1'b1;
    bus8.adc_valid_i = 1'b0;
    bus8.adc_last_i  = 1'b0;
    bus8.ADCOUT      = '0;
    bus8.ready_i     = 1'b1;
    test_reset();
    test_full_scale();
    test_single_beat();
    test_backpressure();
    test_force_drain();
    test_saturation();
    test_reset_mid_drain();
    test_signed();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
